keypad_entry_ctrl: RTL and testbench
====================================

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16: clk cycles per scanner step; legal 1..65535.
REQ-002 SHALL have parameter MAX_DIGITS, default 4: entry capacity in BCD digits; legal 1..4.
REQ-003 SHALL have parameter TIMEOUT, default 24'd1000000: idle cycles before a partial entry is discarded; legal 2..2^24-1.
REQ-004 SHALL have one clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have numbers  input  10  debounced level per digit key 9..0 from the 3x4 scanner, synchronous to clk.
REQ-007 SHALL have asterisk  input  1  debounced '*' level.
REQ-008 SHALL have hash  input  1  debounced '#' level.
REQ-009 SHALL have scan_en  output  1  enable strobe to the scanner's en input.
REQ-010 SHALL have key_strobe  output  1  one-cycle pulse per accepted key press.
REQ-011 SHALL have key_code  output  4  code of last accepted key: 0-9 digits, 10 '*', 11 '#'.
REQ-012 SHALL have entry  output  16  BCD digits, most recent digit in [3:0], unused upper nibbles 0.
REQ-013 SHALL have entry_len  output  3  number of valid digits, 0..MAX_DIGITS.
REQ-014 SHALL have entry_valid  output  1  completed entry offered to consumer.
REQ-015 SHALL have entry_ready  input  1  consumer accepts entry.
REQ-016 SHALL have error  output  1  one-cycle pulse on rejected input.
REQ-017 SHALL have timeout  output  1  one-cycle pulse when a partial entry is discarded.

Function
REQ-018 SHALL drive scan_en high exactly one cycle in every SCAN_DIV cycles (free-running divider, high at count SCAN_DIV-1); SCAN_DIV=1 gives constant high.
REQ-019 SHALL register the 12-bit key vector {hash, asterisk, numbers} each cycle as prev.
REQ-020 SHALL accept a key press only when prev == 0 and the current vector has exactly one bit set; key_strobe and key_code update in the following cycle (1-cycle latency).
REQ-021 SHALL, when prev == 0 and the current vector has two or more bits set, pulse error one cycle later and accept no key.
REQ-022 SHALL ignore vector changes while prev != 0 (key roll-over without release produces no event).
REQ-023 SHALL implement states IDLE (len 0), ENTRY (len 1..MAX_DIGITS), PENDING (entry_valid high).
REQ-024 SHALL, on digit in IDLE/ENTRY with len < MAX_DIGITS, set entry <= {entry[11:0], digit} masked to MAX_DIGITS nibbles, len+1, go ENTRY, in the key_strobe cycle.
REQ-025 SHALL, on digit with len == MAX_DIGITS, drop the digit and pulse error in the key_strobe cycle.
REQ-026 SHALL, on '*' with len > 0, backspace: entry <= entry >> 4, len-1, go IDLE if len becomes 0; on '*' with len == 0 do nothing, no error.
REQ-027 SHALL, on '#' with len > 0, go PENDING and assert entry_valid; on '#' with len == 0 pulse error.
REQ-028 SHALL hold entry, entry_len, entry_valid stable in PENDING until entry_ready sampled high; then clear entry, len, entry_valid and go IDLE next cycle.
REQ-029 SHALL, in PENDING, still pulse key_strobe for accepted keys but not alter entry and not pulse error.
REQ-030 SHALL count cycles in ENTRY since the last accepted key; at count TIMEOUT-1 clear entry and len, go IDLE, pulse timeout; counter is 0 outside ENTRY.
REQ-031 SHALL, when a key is accepted in the cycle the timeout would fire, apply the key and restart the counter; no timeout pulse.
REQ-032 SHALL, when entry_ready is high in the same cycle a key is accepted in PENDING, complete the handshake and discard the key.

Reset
REQ-033 SHALL, while rst_n low, force state IDLE, prev 0, all counters 0, entry 0, entry_len 0, key_code 0, scan_en/key_strobe/entry_valid/error/timeout 0.
REQ-034 SHALL, on reset mid-entry or in PENDING, discard the entry without a timeout pulse; first key after release requires prev == 0.

Verification
REQ-035 SHALL check: press 1,2,3,# (each released between) -> entry 16'h0123, entry_len 3, entry_valid high until entry_ready, then all 0.
REQ-036 SHALL check: 5 digits 1..5 with MAX_DIGITS=4 -> entry 16'h1234, error pulse on '5'; then '*' -> entry 16'h0123, len 3.
REQ-037 SHALL check: numbers=10'b0000000011 from idle -> error pulse, no key_strobe; '#' with len 0 -> error pulse.
REQ-038 SHALL check: TIMEOUT=8, press 7 then idle 7 cycles -> timeout pulse, entry 0, len 0; key in the firing cycle -> no timeout.
REQ-039 SHALL check: SCAN_DIV=4 -> scan_en pattern 0001 repeating from reset; rst_n low during PENDING -> entry_valid 0 immediately.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: scanner enable divider, single-key press detection,
// BCD digit entry with backspace/submit, consumer handshake and idle timeout.
module keypad_entry_ctrl #(
  parameter int unsigned SCAN_DIV   = 16,
  parameter int unsigned MAX_DIGITS = 4,
  parameter logic [23:0] TIMEOUT    = 24'd1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  numbers,
  input  logic        asterisk,
  input  logic        hash,
  output logic        scan_en,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic [15:0] entry,
  output logic [2:0]  entry_len,
  output logic        entry_valid,
  input  logic        entry_ready,
  output logic        error,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    PENDING
  } state_t;

  localparam logic [15:0] DIV_LAST   = 16'(SCAN_DIV - 1);
  localparam logic [2:0]  MAX_LEN    = 3'(MAX_DIGITS);
  localparam logic [15:0] ENTRY_MASK = 16'((32'd1 << (4 * MAX_DIGITS)) - 32'd1);
  localparam logic [23:0] TO_LAST    = TIMEOUT - 24'd1;
  localparam logic [3:0]  CODE_STAR  = 4'd10;
  localparam logic [3:0]  CODE_HASH  = 4'd11;

  // Scanner enable divider; scan_en is registered alongside the count so it
  // tracks count == SCAN_DIV-1 and stays low during reset.
  logic [15:0] div_cnt;
  logic [15:0] div_nxt;

  assign div_nxt = (div_cnt == DIV_LAST) ? 16'd0 : div_cnt + 16'd1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      scan_en <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      scan_en <= (div_nxt == DIV_LAST);
    end
  end

  // Press detection: a key counts only on a rising edge out of all-released.
  logic [11:0] keys;
  logic [11:0] prev;
  logic        prev_idle;
  logic        multi;
  logic        accept;
  logic        multi_err;
  logic [3:0]  key_idx;

  assign keys      = {hash, asterisk, numbers};
  assign prev_idle = (prev == 12'd0);
  assign multi     = ((keys & (keys - 12'd1)) != 12'd0);
  assign accept    = prev_idle && (keys != 12'd0) && !multi;
  assign multi_err = prev_idle && multi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= keys;
  end

  always_comb begin
    key_idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (keys[i]) key_idx = 4'(i);
    end
  end

  // Entry FSM
  state_t      state, state_n;
  logic [15:0] entry_n;
  logic [2:0]  len_n;
  logic [23:0] tcnt, tcnt_n;
  logic        key_strobe_n;
  logic [3:0]  key_code_n;
  logic        error_n;
  logic        timeout_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      entry      <= '0;
      entry_len  <= '0;
      tcnt       <= '0;
      key_strobe <= 1'b0;
      key_code   <= '0;
      error      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      entry      <= entry_n;
      entry_len  <= len_n;
      tcnt       <= tcnt_n;
      key_strobe <= key_strobe_n;
      key_code   <= key_code_n;
      error      <= error_n;
      timeout    <= timeout_n;
    end
  end

  assign entry_valid = (state == PENDING);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_n      = state;
    entry_n      = entry;
    len_n        = entry_len;
    tcnt_n       = 24'd0;
    key_strobe_n = accept;
    key_code_n   = accept ? key_idx : key_code;
    error_n      = 1'b0;
    timeout_n    = 1'b0;

    unique case (state)
      IDLE, ENTRY: begin
        error_n = multi_err;
        if (accept) begin
          if (key_idx == CODE_STAR) begin
            if (entry_len != 3'd0) begin
              entry_n = entry >> 4;
              len_n   = entry_len - 3'd1;
              state_n = (entry_len == 3'd1) ? IDLE : ENTRY;
            end
          end else if (key_idx == CODE_HASH) begin
            if (entry_len != 3'd0) state_n = PENDING;
            else                   error_n = 1'b1;
          end else if (entry_len < MAX_LEN) begin
            entry_n = {entry[11:0], key_idx} & ENTRY_MASK;
            len_n   = entry_len + 3'd1;
            state_n = ENTRY;
          end else begin
            error_n = 1'b1;
          end
        end else if (state == ENTRY) begin
          if (tcnt == TO_LAST) begin
            entry_n   = '0;
            len_n     = '0;
            state_n   = IDLE;
            timeout_n = 1'b1;
          end else begin
            tcnt_n = tcnt + 24'd1;
          end
        end
      end
      PENDING: begin
        // Keys still strobe here but never touch the held entry.
        if (entry_ready) begin
          entry_n = '0;
          len_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with SCAN_DIV=4, MAX_DIGITS=4, TIMEOUT=8;
// expected values are hand-derived per cycle.
module tb_keypad_entry_ctrl;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic [9:0]  numbers;
  logic        asterisk;
  logic        hash;
  logic        scan_en;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic [2:0]  entry_len;
  logic        entry_valid;
  logic        entry_ready;
  logic        error;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  keypad_entry_ctrl #(
    .SCAN_DIV  (4),
    .MAX_DIGITS(4),
    .TIMEOUT   (24'd8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .numbers    (numbers),
    .asterisk   (asterisk),
    .hash       (hash),
    .scan_en    (scan_en),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .entry      (entry),
    .entry_len  (entry_len),
    .entry_valid(entry_valid),
    .entry_ready(entry_ready),
    .error      (error),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] v);
    {hash, asterisk, numbers} = v;
  endtask

  function automatic logic [11:0] dig(input int d);
    logic [11:0] one;
    one = 12'd1;
    return one << d;
  endfunction

  localparam logic [11:0] STAR = 12'h400;
  localparam logic [11:0] HASH = 12'h800;

  task automatic press(input logic [11:0] v);
    drive(v);
    tick();
  endtask

  task automatic rel();
    drive('0);
    tick();
    check("strobe_one_cycle", {31'd0, key_strobe}, 32'd0);
  endtask

  // Called in the key_strobe cycle of the last accepted key.
  task automatic idle_to_timeout();
    drive('0);
    for (int i = 1; i < TO; i++) begin
      tick();
      check("no_early_timeout", {31'd0, timeout}, 32'd0);
    end
    tick();
    check("timeout_pulse", {31'd0, timeout}, 32'd1);
    check("timeout_entry", {16'd0, entry}, 32'd0);
    check("timeout_len", {29'd0, entry_len}, 32'd0);
    tick();
    check("timeout_once", {31'd0, timeout}, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    entry_ready = 1'b0;
    drive('0);
    tick();
    tick();
    check("rst_scan_en", {31'd0, scan_en}, 32'd0);
    check("rst_strobe", {31'd0, key_strobe}, 32'd0);
    check("rst_code", {28'd0, key_code}, 32'd0);
    check("rst_entry", {16'd0, entry}, 32'd0);
    check("rst_len", {29'd0, entry_len}, 32'd0);
    check("rst_valid", {31'd0, entry_valid}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);

    // scan_en pattern 0,0,0,1 repeating from reset release
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("scan_en_pattern", {31'd0, scan_en}, (i % 4 == 3) ? 32'd1 : 32'd0);
      tick();
    end

    // 1,2,3,# then handshake
    press(dig(1));
    check("d1_strobe", {31'd0, key_strobe}, 32'd1);
    check("d1_code", {28'd0, key_code}, 32'd1);
    check("d1_entry", {16'd0, entry}, 32'h0001);
    rel();
    press(dig(2));
    check("d2_entry", {16'd0, entry}, 32'h0012);
    rel();
    press(dig(3));
    check("d3_entry", {16'd0, entry}, 32'h0123);
    check("d3_len", {29'd0, entry_len}, 32'd3);
    rel();
    press(HASH);
    check("hash_code", {28'd0, key_code}, 32'd11);
    check("hash_valid", {31'd0, entry_valid}, 32'd1);
    check("hash_error", {31'd0, error}, 32'd0);
    rel();
    tick();
    check("pend_hold_valid", {31'd0, entry_valid}, 32'd1);
    press(dig(5));
    check("pend_strobe", {31'd0, key_strobe}, 32'd1);
    check("pend_code", {28'd0, key_code}, 32'd5);
    check("pend_entry", {16'd0, entry}, 32'h0123);
    check("pend_len", {29'd0, entry_len}, 32'd3);
    check("pend_no_error", {31'd0, error}, 32'd0);
    rel();
    check("pend_valid_still", {31'd0, entry_valid}, 32'd1);
    entry_ready = 1'b1;
    tick();
    entry_ready = 1'b0;
    check("ack_valid", {31'd0, entry_valid}, 32'd0);
    check("ack_entry", {16'd0, entry}, 32'd0);
    check("ack_len", {29'd0, entry_len}, 32'd0);

    // overflow and backspace
    for (int d = 1; d <= 4; d++) begin
      press(dig(d));
      rel();
    end
    check("four_entry", {16'd0, entry}, 32'h1234);
    check("four_len", {29'd0, entry_len}, 32'd4);
    press(dig(5));
    check("ovf_strobe", {31'd0, key_strobe}, 32'd1);
    check("ovf_error", {31'd0, error}, 32'd1);
    check("ovf_entry", {16'd0, entry}, 32'h1234);
    rel();
    check("ovf_error_once", {31'd0, error}, 32'd0);
    press(STAR);
    check("bs_code", {28'd0, key_code}, 32'd10);
    check("bs_entry", {16'd0, entry}, 32'h0123);
    check("bs_len", {29'd0, entry_len}, 32'd3);
    check("bs_error", {31'd0, error}, 32'd0);
    rel();
    for (int i = 0; i < 3; i++) begin
      press(STAR);
      rel();
    end
    check("bs_all_entry", {16'd0, entry}, 32'd0);
    check("bs_all_len", {29'd0, entry_len}, 32'd0);

    // two keys at once, '#' and '*' on empty entry, roll-over
    drive(12'h003);
    tick();
    check("multi_error", {31'd0, error}, 32'd1);
    check("multi_strobe", {31'd0, key_strobe}, 32'd0);
    check("multi_len", {29'd0, entry_len}, 32'd0);
    rel();
    check("multi_error_once", {31'd0, error}, 32'd0);
    press(HASH);
    check("hash_empty_error", {31'd0, error}, 32'd1);
    check("hash_empty_valid", {31'd0, entry_valid}, 32'd0);
    rel();
    press(STAR);
    check("star_empty_strobe", {31'd0, key_strobe}, 32'd1);
    check("star_empty_error", {31'd0, error}, 32'd0);
    check("star_empty_len", {29'd0, entry_len}, 32'd0);
    rel();
    press(dig(4));
    check("roll_first", {16'd0, entry}, 32'h0004);
    drive(dig(6));
    tick();
    check("roll_no_strobe", {31'd0, key_strobe}, 32'd0);
    check("roll_entry", {16'd0, entry}, 32'h0004);
    rel();
    press(STAR);
    check("roll_clear_len", {29'd0, entry_len}, 32'd0);
    rel();

    // timeout, then a key landing in the firing cycle
    press(dig(7));
    check("to_entry", {16'd0, entry}, 32'h0007);
    idle_to_timeout();
    press(dig(7));
    drive('0);
    for (int i = 1; i < TO; i++) tick();
    press(dig(8));
    check("fire_key_strobe", {31'd0, key_strobe}, 32'd1);
    check("fire_key_no_to", {31'd0, timeout}, 32'd0);
    check("fire_key_entry", {16'd0, entry}, 32'h0078);
    check("fire_key_len", {29'd0, entry_len}, 32'd2);
    idle_to_timeout();

    // reset while an entry is pending
    press(dig(9));
    rel();
    press(HASH);
    check("pre_rst_valid", {31'd0, entry_valid}, 32'd1);
    rel();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, entry_valid}, 32'd0);
    check("async_rst_entry", {16'd0, entry}, 32'd0);
    check("async_rst_len", {29'd0, entry_len}, 32'd0);
    tick();
    check("rst_no_timeout", {31'd0, timeout}, 32'd0);
    rst_n = 1'b1;
    press(dig(3));
    check("post_rst_strobe", {31'd0, key_strobe}, 32'd1);
    check("post_rst_entry", {16'd0, entry}, 32'h0003);
    rel();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
